// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - constants shared by fetch and decode
package mips_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    // What the IF/ID register does on the coming edge.
    typedef enum logic [1:0] {
        IFID_HOLD  = 2'd0,
        IFID_LOAD  = 2'd1,
        IFID_FLUSH = 2'd2
    } ifid_op_t;

endpackage

// File: rtl/pc_select.sv
// rtl/pc_select.sv - next-PC, IF/ID action and halt decision for the fetch stage
module pc_select
    import mips_pkg::*;
#(
    parameter logic [31:0] HALT_WORD = mips_pkg::HALT_WORD
) (
    input  logic [31:0] pc,
    input  logic [31:0] if_id_pc_plus4,
    input  logic        if_id_valid,
    input  logic        halted,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic        jr,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    input  logic [31:0] imem_data,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output ifid_op_t    ifid_op,
    output logic        halted_next
);

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        next_pc     = pc;
        ifid_op     = IFID_HOLD;
        halted_next = halted;
        if (branch_taken) begin
            next_pc     = branch_target;
            ifid_op     = IFID_FLUSH;
            halted_next = 1'b0;
        end else if (jump && !stall && if_id_valid) begin
            next_pc     = jr ? jr_target : {if_id_pc_plus4[31:28], jump_index, 2'b00};
            ifid_op     = IFID_FLUSH;
            halted_next = 1'b0;
        end else if (stall) begin
            ifid_op = IFID_HOLD;
        end else if (halted) begin
            ifid_op = IFID_FLUSH;
        end else if (imem_data == HALT_WORD) begin
            // The halt word itself still goes to decode; only the PC freezes.
            ifid_op     = IFID_LOAD;
            halted_next = 1'b1;
        end else begin
            next_pc = pc_plus4;
            ifid_op = IFID_LOAD;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, IF/ID pipeline register and halt flag
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int          IMEM_AW   = 8,
    parameter logic [31:0] HALT_WORD = mips_pkg::HALT_WORD
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic               jr,
    input  logic [25:0]        jump_index,
    input  logic [31:0]        jr_target,
    input  logic [31:0]        imem_data,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        pc,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc_plus4,
    output logic               if_id_valid,
    output logic               halted
);

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    ifid_op_t    ifid_op;
    logic        halted_next;

    assign imem_addr = pc[IMEM_AW+1:2];

    pc_select #(
        .HALT_WORD(HALT_WORD)
    ) u_pc_select (
        .pc             (pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jr             (jr),
        .jump_index     (jump_index),
        .jr_target      (jr_target),
        .imem_data      (imem_data),
        .pc_plus4       (pc_plus4),
        .next_pc        (next_pc),
        .ifid_op        (ifid_op),
        .halted_next    (halted_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc             <= PC_RESET;
            if_id_instr    <= NOP_WORD;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
            halted         <= 1'b0;
        end else begin
            pc     <= next_pc;
            halted <= halted_next;
            // A bubble keeps the old PC+4; decode ignores it while valid is low.
            unique case (ifid_op)
                IFID_LOAD: begin
                    if_id_instr    <= imem_data;
                    if_id_pc_plus4 <= pc_plus4;
                    if_id_valid    <= 1'b1;
                end
                IFID_FLUSH: begin
                    if_id_instr <= NOP_WORD;
                    if_id_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized bench for fetch_stage against a behavioural model
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic        jr;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic [31:0] imem_data;
    logic [7:0]  imem_addr;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;

    logic [31:0] mem [256];
    assign imem_data = mem[imem_addr];

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halted;

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jr             (jr),
        .jump_index     (jump_index),
        .jr_target      (jr_target),
        .imem_data      (imem_data),
        .imem_addr      (imem_addr),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .halted         (halted)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h exp %08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = 32'h0;
        m_instr  = 32'h0;
        m_pc4    = 32'h0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] word;
        word = mem[m_pc[9:2]];
        if (reset) begin
            model_reset();
        end else if (branch_taken) begin
            m_pc = branch_target; m_instr = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
        end else if (jump && !stall && m_valid) begin
            m_pc = jr ? jr_target : {m_pc4[31:28], jump_index, 2'b00};
            m_instr = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
        end else if (stall) begin
            // everything holds
        end else if (m_halted) begin
            m_instr = 32'h0; m_valid = 1'b0;
        end else begin
            m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            if (word == 32'hFFFF_FFFF) m_halted = 1'b1;
            else                       m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all();
        check("pc", pc, m_pc);
        check("imem_addr", {24'h0, imem_addr}, {24'h0, m_pc[9:2]});
        check("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
        check("if_id_instr", if_id_instr, m_instr);
        check("halted", {31'h0, halted}, {31'h0, m_halted});
        if (m_valid) check("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic idle();
        stall = 0; branch_taken = 0; branch_target = 0;
        jump = 0; jr = 0; jump_index = 0; jr_target = 0;
    endtask

    task automatic branch_to(input logic [31:0] t);
        idle();
        branch_taken = 1; branch_target = t;
        cycle();
        idle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            if (mem[i] == 32'hFFFF_FFFF) mem[i] = 32'h0;
        end
        mem[0] = 32'h2001_0005;
        idle();
        model_reset();

        // reset and stream
        reset = 1;
        repeat (3) cycle();
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'h0, if_id_valid}, 32'h0);
        reset = 0;
        cycle();
        check("t1_instr", if_id_instr, 32'h2001_0005);
        check("t1_pc4", if_id_pc_plus4, 32'h4);
        check("t1_valid", {31'h0, if_id_valid}, 32'h1);
        check("t1_pc", pc, 32'h4);
        cycle();
        check("t1_pc8", pc, 32'h8);

        // stall
        stall = 1;
        cycle();
        check("stall_pc_a", pc, 32'h8);
        cycle();
        check("stall_pc_b", pc, 32'h8);
        check("stall_pc4", if_id_pc_plus4, 32'h8);
        stall = 0;
        cycle();
        check("stall_rel_pc", pc, 32'hC);

        // branch flush ignores stall
        branch_taken = 1; branch_target = 32'h40; stall = 1;
        cycle();
        check("br_pc", pc, 32'h40);
        check("br_valid", {31'h0, if_id_valid}, 32'h0);
        check("br_instr", if_id_instr, 32'h0);
        idle();

        // jumps
        branch_to(32'h1000_000C);
        cycle();
        check("j_base", if_id_pc_plus4, 32'h1000_0010);
        jump = 1; jump_index = 26'h000_0020;
        cycle();
        check("j_pc", pc, 32'h1000_0080);
        check("j_valid", {31'h0, if_id_valid}, 32'h0);
        idle();
        cycle();
        jump = 1; jr = 1; jr_target = 32'h100;
        cycle();
        check("jr_pc", pc, 32'h100);
        idle();
        cycle();
        jump = 1; jump_index = 26'h3FF_FFFF; branch_taken = 1; branch_target = 32'h200;
        cycle();
        check("jb_pc", pc, 32'h200);
        idle();

        // halt
        mem[5] = 32'hFFFF_FFFF;
        branch_to(32'h10);
        cycle();
        cycle();
        check("h_halted", {31'h0, halted}, 32'h1);
        check("h_pc", pc, 32'h14);
        check("h_instr", if_id_instr, 32'hFFFF_FFFF);
        cycle();
        check("h_bubble", {31'h0, if_id_valid}, 32'h0);
        check("h_pc2", pc, 32'h14);
        branch_to(32'h8);
        check("h_clr", {31'h0, halted}, 32'h0);
        check("h_br_pc", pc, 32'h8);

        // asynchronous reset between edges
        mem[12] = 32'hFFFF_FFFF;
        branch_to(32'h30);
        cycle();
        check("ar_pre_halted", {31'h0, halted}, 32'h1);
        check("ar_pre_pc", pc, 32'h30);
        #2;
        reset = 1;
        #1;
        check("ar_pc", pc, 32'h0);
        check("ar_halted", {31'h0, halted}, 32'h0);
        check("ar_valid", {31'h0, if_id_valid}, 32'h0);
        model_reset();
        cycle();
        reset = 0;
        cycle();

        // random
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom % 150) == 0;
            stall        = ($urandom % 5) == 0;
            branch_taken = ($urandom % 10) == 0;
            if ($urandom % 8 == 0) branch_target = $urandom;
            else branch_target = {22'h0, 8'($urandom), 2'($urandom % 4 == 0 ? 1 : 0)};
            jump         = ($urandom % 8) == 0;
            jr           = $urandom % 2;
            jump_index   = 26'($urandom);
            jr_target    = ($urandom % 4 == 0) ? $urandom : {22'h0, 8'($urandom), 2'b00};
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
